// File: rtl/yutorina_bus_unit.sv
// yutorina_bus_unit: CPU-side memory access unit. Addresses whose upper bits
// match SPM_TAG go straight to the scratch-pad with no added latency; all
// other addresses become an arbitrated bus transaction
// (IDLE -> REQ -> ACCESS -> [WAIT] -> IDLE), optionally bounded by a timeout.
//
// Handshake semantics (all strobes active low):
//   - CPU side: a request is presented while as_=0. The unit accepts it only in
//     IDLE. For a bus access busy=1 tells the CPU to hold off, and the cycle in
//     which busy drops carries the result on rd_data. SPM accesses never
//     assert busy.
//   - Bus side: bus_req_ stays low from acceptance until the transfer ends.
//     bus_as_ is low for exactly the single cycle in which bus_grnt_=0 is seen
//     in REQ. The transfer then ends on the first cycle with bus_rdy_=0.
//     bus_addr/bus_w_data read as 0 and bus_rw as 1 outside that strobe cycle.
module yutorina_bus_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int SPM_ADDR_W = 12,
  parameter int SPM_TAG    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_w_data,
  input  logic [DATA_W-1:0]     spm_r_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_w_data,
  input  logic [DATA_W-1:0]     bus_r_data,
  input  logic                  bus_rdy_,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int TAG_W = ADDR_W - SPM_ADDR_W;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TAG_W-1:0] TAG      = TAG_W'(SPM_TAG);
  // The timeout fires in the TIMEOUT-th cycle after entering REQ. The counter
  // reads 0 in the first such cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               TMO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_rw;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rd_buf;
  logic [CNT_W-1:0]    cnt;

  logic hit, spm_sel, start, tmo_hit;
  logic latch, buf_ld, cnt_clr, cnt_inc;

  assign hit       = (addr[ADDR_W-1:SPM_ADDR_W] == TAG);
  // New requests are only taken in IDLE. A flush cancels them outright.
  assign spm_sel   = (state == S_IDLE) && !as_ && hit && !flush;
  assign start     = (state == S_IDLE) && !as_ && !hit && !flush;
  assign tmo_hit   = TMO_EN && (cnt == CNT_LAST);
  assign dbg_state = state;

  // Scratch-pad path: address, direction and data pass straight through.
  assign spm_as_    = !spm_sel;
  assign spm_addr   = addr[SPM_ADDR_W-1:0];
  assign spm_rw     = rw;
  assign spm_w_data = wr_data;

  // Next-state and all handshake/data outputs for the bus sequencer.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    rd_data    = '0;
    bus_req_   = 1'b1;
    bus_as_    = 1'b1;
    bus_addr   = '0;
    bus_rw     = 1'b1;
    bus_w_data = '0;
    err        = 1'b0;
    latch      = 1'b0;
    buf_ld     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (spm_sel) begin
          rd_data = spm_r_data;
        end else if (start) begin
          bus_req_  = 1'b0;
          busy      = 1'b1;
          latch     = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          // Timeout beats a grant arriving in the same cycle: no strobe issued.
          err       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          bus_req_ = 1'b0;
          busy     = 1'b1;
          cnt_inc  = 1'b1;
          if (!bus_grnt_) begin
            bus_as_    = 1'b0;
            bus_addr   = lat_addr;
            bus_rw     = lat_rw;
            bus_w_data = lat_wdata;
            state_nxt  = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        bus_req_ = 1'b0;
        if (!bus_rdy_) begin
          // Ready wins over a coincident timeout. Flush cannot abort here.
          rd_data   = lat_rw ? bus_r_data : '0;
          buf_ld    = 1'b1;
          state_nxt = stall ? S_WAIT : S_IDLE;
        end else if (tmo_hit) begin
          bus_req_  = 1'b1;
          err       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          busy    = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      S_WAIT: begin
        // Replays the completed read while the pipeline is stalled.
        rd_data = rd_buf;
        if (!stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request capture at acceptance, so the CPU may change its inputs afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_rw    <= 1'b1;
      lat_wdata <= '0;
    end else if (latch) begin
      lat_addr  <= addr;
      lat_rw    <= rw;
      lat_wdata <= wr_data;
    end
  end

  // Read buffer holding the bus data returned on the ready cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_buf <= '0;
    else if (buf_ld) rd_buf <= bus_r_data;
  end

  // Timeout counter: cleared on acceptance, saturating so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt <= '0;
    else if (cnt_clr)                   cnt <= '0;
    else if (cnt_inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

endmodule
